// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: parametrised UART receiver with parity, framing and break detection
module uart_rx_cfg #(
    parameter int CLKS_PER_BIT = 87,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 in_Clk,
    input  logic                 in_Reset,
    input  logic                 in_RX_Serial,
    output logic                 out_RX_DV,
    output logic [DATA_BITS-1:0] out_RX_Byte,
    output logic                 out_Parity_Err,
    output logic                 out_Frame_Err,
    output logic                 out_Break
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] MID    = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF   = CW'((CLKS_PER_BIT - 1) / 2);
    localparam logic [IW-1:0] LAST_D = IW'(DATA_BITS - 1);
    localparam logic [IW-1:0] LAST_S = IW'(STOP_BITS - 1);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, CLEAN, WAIT_IDLE} state_t;
    state_t                state_q;
    logic                  meta_q, rx_s_q;
    logic [CW-1:0]         cnt_q;
    logic [IW-1:0]         idx_q;
    logic [DATA_BITS-1:0]  shift_q, byte_q;
    logic                  perr_q, ferr_q, zero_q, stop_ok_q;
    logic                  dv_q, pe_q, fe_q, br_q;
    logic                  at_mid;
    assign at_mid         = cnt_q == MID;
    assign out_RX_DV      = dv_q;
    assign out_RX_Byte    = byte_q;
    assign out_Parity_Err = pe_q;
    assign out_Frame_Err  = fe_q;
    assign out_Break      = br_q;
    // two-flop synchroniser for the asynchronous serial line, idle high
    always_ff @(posedge in_Clk or negedge in_Reset) begin
        if (!in_Reset) begin
            meta_q <= 1'b1;
            rx_s_q <= 1'b1;
        end else begin
            meta_q <= in_RX_Serial;
            rx_s_q <= meta_q;
        end
    end
    // frame FSM: mid-bit sampling, pending error tracking, outputs published only in CLEAN
    always_ff @(posedge in_Clk or negedge in_Reset) begin
        if (!in_Reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            shift_q   <= '0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            zero_q    <= 1'b1;
            stop_ok_q <= 1'b1;
            dv_q      <= 1'b0;
            byte_q    <= '0;
            pe_q      <= 1'b0;
            fe_q      <= 1'b0;
            br_q      <= 1'b0;
        end else begin
            dv_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    cnt_q  <= '0;
                    idx_q  <= '0;
                    perr_q <= 1'b0;
                    ferr_q <= 1'b0;
                    zero_q <= 1'b1;
                    if (!rx_s_q) state_q <= START;
                end
                START: begin
                    if (cnt_q == HALF) begin
                        cnt_q   <= '0;
                        state_q <= rx_s_q ? IDLE : DATA;
                    end else cnt_q <= cnt_q + CW'(1);
                end
                DATA: begin
                    if (at_mid) begin
                        cnt_q   <= '0;
                        shift_q <= {rx_s_q, shift_q[DATA_BITS-1:1]};
                        zero_q  <= zero_q & ~rx_s_q;
                        idx_q   <= idx_q == LAST_D ? '0 : idx_q + IW'(1);
                        if (idx_q == LAST_D) state_q <= PARITY_EN != 0 ? PARITY : STOP;
                    end else cnt_q <= cnt_q + CW'(1);
                end
                PARITY: begin
                    if (at_mid) begin
                        cnt_q   <= '0;
                        perr_q  <= rx_s_q != ((^shift_q) ^ (PARITY_ODD != 0));
                        zero_q  <= zero_q & ~rx_s_q;
                        state_q <= STOP;
                    end else cnt_q <= cnt_q + CW'(1);
                end
                STOP: begin
                    if (at_mid) begin
                        cnt_q  <= '0;
                        ferr_q <= ferr_q | ~rx_s_q;
                        zero_q <= zero_q & ~rx_s_q;
                        idx_q  <= idx_q == LAST_S ? '0 : idx_q + IW'(1);
                        if (idx_q == LAST_S) begin
                            stop_ok_q <= rx_s_q;
                            state_q   <= CLEAN;
                        end
                    end else cnt_q <= cnt_q + CW'(1);
                end
                CLEAN: begin
                    dv_q    <= 1'b1;
                    byte_q  <= shift_q;
                    pe_q    <= perr_q;
                    fe_q    <= ferr_q;
                    br_q    <= ferr_q & zero_q;
                    state_q <= stop_ok_q ? IDLE : WAIT_IDLE;
                end
                WAIT_IDLE: if (rx_s_q) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb_uart_rx_cfg: scoreboard bench for uart_rx_cfg in 8N1, 7E1 and 8N2 configurations
module tb_uart_rx_cfg;
    logic clk = 1'b0;
    logic rst_n, rx_a, rx_b, rx_c;
    logic dv_a, pe_a, fe_a, br_a, dv_b, pe_b, fe_b, br_b, dv_c, pe_c, fe_c, br_c;
    logic [7:0] byte_a, byte_c;
    logic [6:0] byte_b;
    logic pdv_a = 1'b0, pdv_b = 1'b0, pdv_c = 1'b0;
    logic [15:0] qa[$], qb[$], qc[$];
    int n_assert = 0, n_fail = 0;
    always #5 clk = ~clk;
    uart_rx_cfg #(.CLKS_PER_BIT(8)) u_a (
        .in_Clk(clk), .in_Reset(rst_n), .in_RX_Serial(rx_a), .out_RX_DV(dv_a),
        .out_RX_Byte(byte_a), .out_Parity_Err(pe_a), .out_Frame_Err(fe_a), .out_Break(br_a));
    uart_rx_cfg #(.CLKS_PER_BIT(8), .DATA_BITS(7), .PARITY_EN(1), .PARITY_ODD(0)) u_b (
        .in_Clk(clk), .in_Reset(rst_n), .in_RX_Serial(rx_b), .out_RX_DV(dv_b),
        .out_RX_Byte(byte_b), .out_Parity_Err(pe_b), .out_Frame_Err(fe_b), .out_Break(br_b));
    uart_rx_cfg #(.CLKS_PER_BIT(8), .STOP_BITS(2)) u_c (
        .in_Clk(clk), .in_Reset(rst_n), .in_RX_Serial(rx_c), .out_RX_DV(dv_c),
        .out_RX_Byte(byte_c), .out_Parity_Err(pe_c), .out_Frame_Err(fe_c), .out_Break(br_c));
    function automatic logic [15:0] pk(input logic dv, input logic [8:0] d, input logic pe, input logic fe, input logic br);
        return {3'b0, dv, d, pe, fe, br};
    endfunction
    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask
    task automatic drive(input int sel, input logic v, input int n);
        case (sel)
            0: rx_a = v;
            1: rx_b = v;
            default: rx_c = v;
        endcase
        repeat (n) @(negedge clk);
    endtask
    task automatic send(input int sel, input logic [15:0] bits, input int len);
        for (int i = 0; i < len; i++) drive(sel, bits[i], 8);
    endtask
    always @(negedge clk) begin
        if (dv_a) begin
            chk("a_dv_width", {15'b0, pdv_a}, 16'h0);
            chk("a_dv_expected", {15'b0, qa.size() != 0}, 16'h1);
            if (qa.size() != 0) chk("a_frame", pk(1'b1, {1'b0, byte_a}, pe_a, fe_a, br_a), qa.pop_front());
        end
        pdv_a = dv_a;
    end
    always @(negedge clk) begin
        if (dv_b) begin
            chk("b_dv_width", {15'b0, pdv_b}, 16'h0);
            chk("b_dv_expected", {15'b0, qb.size() != 0}, 16'h1);
            if (qb.size() != 0) chk("b_frame", pk(1'b1, {2'b0, byte_b}, pe_b, fe_b, br_b), qb.pop_front());
        end
        pdv_b = dv_b;
    end
    always @(negedge clk) begin
        if (dv_c) begin
            chk("c_dv_width", {15'b0, pdv_c}, 16'h0);
            chk("c_dv_expected", {15'b0, qc.size() != 0}, 16'h1);
            if (qc.size() != 0) chk("c_frame", pk(1'b1, {1'b0, byte_c}, pe_c, fe_c, br_c), qc.pop_front());
        end
        pdv_c = dv_c;
    end
    initial begin
        rst_n = 1'b1;
        rx_a = 1'b1;
        rx_b = 1'b1;
        rx_c = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("a_reset", pk(dv_a, {1'b0, byte_a}, pe_a, fe_a, br_a), 16'h0);
        chk("b_reset", pk(dv_b, {2'b0, byte_b}, pe_b, fe_b, br_b), 16'h0);
        chk("c_reset", pk(dv_c, {1'b0, byte_c}, pe_c, fe_c, br_c), 16'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        drive(0, 1'b1, 16);
        qa.push_back(pk(1'b1, 9'h0A5, 1'b0, 1'b0, 1'b0));
        send(0, {6'b0, 1'b1, 8'hA5, 1'b0}, 10);
        drive(0, 1'b1, 16);
        qb.push_back(pk(1'b1, 9'h053, 1'b0, 1'b0, 1'b0));
        send(1, {6'b0, 1'b1, 1'b0, 7'h53, 1'b0}, 10);
        drive(1, 1'b1, 16);
        qb.push_back(pk(1'b1, 9'h053, 1'b1, 1'b0, 1'b0));
        send(1, {6'b0, 1'b1, 1'b1, 7'h53, 1'b0}, 10);
        drive(1, 1'b1, 16);
        qc.push_back(pk(1'b1, 9'h03C, 1'b0, 1'b1, 1'b0));
        send(2, {5'b0, 1'b0, 1'b1, 8'h3C, 1'b0}, 11);
        drive(2, 1'b0, 40);
        drive(2, 1'b1, 16);
        qc.push_back(pk(1'b1, 9'h03C, 1'b0, 1'b0, 1'b0));
        send(2, {5'b0, 2'b11, 8'h3C, 1'b0}, 11);
        drive(2, 1'b1, 16);
        qa.push_back(pk(1'b1, 9'h000, 1'b0, 1'b1, 1'b1));
        drive(0, 1'b0, 30 * 8);
        drive(0, 1'b1, 16);
        qa.push_back(pk(1'b1, 9'h011, 1'b0, 1'b0, 1'b0));
        send(0, {6'b0, 1'b1, 8'h11, 1'b0}, 10);
        drive(0, 1'b1, 16);
        drive(0, 1'b0, 2);
        drive(0, 1'b1, 24);
        qa.push_back(pk(1'b1, 9'h0FF, 1'b0, 1'b0, 1'b0));
        send(0, {6'b0, 1'b1, 8'hFF, 1'b0}, 10);
        drive(0, 1'b1, 16);
        send(0, {11'b0, 4'b0001, 1'b0}, 5);
        drive(0, 1'b0, 4);
        rst_n = 1'b0;
        #1;
        chk("a_mid_frame_reset", pk(dv_a, {1'b0, byte_a}, pe_a, fe_a, br_a), 16'h0);
        rx_a = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        drive(0, 1'b1, 16);
        qa.push_back(pk(1'b1, 9'h07E, 1'b0, 1'b0, 1'b0));
        send(0, {6'b0, 1'b1, 8'h7E, 1'b0}, 10);
        drive(0, 1'b1, 40);
        chk("a_drained", 16'(qa.size()), 16'h0);
        chk("b_drained", 16'(qb.size()), 16'h0);
        chk("c_drained", 16'(qc.size()), 16'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
